// File: rtl/retire_stage.sv
// Commit/retire stage: frees superseded PRNs, maintains the retired arn->prn map, trains the predictor.
// Optional statistics counters are built when RETIRE_STATS_EN is defined.
`ifndef N
`define N 3
`endif
`ifndef PRN_WIDTH
`define PRN_WIDTH 6
`endif

module retire_stage #(
    parameter int N         = `N,
    parameter int ARCH_REGS = 32
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [N-1:0]                         ct_valid,
    input  logic [N-1:0][`PRN_WIDTH-1:0]         ct_dest_prn,
    input  logic [N-1:0][4:0]                    ct_dest_arn,
    input  logic [N-1:0]                         ct_success,
    input  logic [N-1:0]                         ct_halt,
    input  logic [N-1:0]                         ct_cond_branch,
    input  logic [N-1:0]                         ct_uncond_branch,
    input  logic [N-1:0][31:0]                   ct_pc,
    input  logic [N-1:0][31:0]                   ct_resolve_target,
    input  logic [N-1:0]                         ct_resolve_taken,
    output logic [N-1:0]                         free_valid,
    output logic [N-1:0][`PRN_WIDTH-1:0]         free_prn,
    output logic [ARCH_REGS-1:0][`PRN_WIDTH-1:0] arch_map,
    output logic [N-1:0]                         bp_valid,
    output logic [N-1:0][31:0]                   bp_pc,
    output logic [N-1:0][31:0]                   bp_target,
    output logic [N-1:0]                         bp_taken,
`ifdef RETIRE_STATS_EN
    output logic [63:0]                          retire_cnt,
    output logic [31:0]                          mispredict_cnt,
`endif
    output logic                                 halted
);

    localparam int PW = `PRN_WIDTH;

    typedef enum logic {RUN, HALTED} state_t;

    state_t state, state_n;

    logic [N-1:0]                 retire_p0;
    logic [N-1:0]                 free_p0;
    logic [N-1:0]                 bp_p0;
    logic [N-1:0][PW-1:0]         old_prn_p0;
    logic [ARCH_REGS-1:0][PW-1:0] map_n_p0;
    logic                         blocked;

    // Old PRN of lane i: youngest older retiring lane writing the same arn wins over the registered map.
    function automatic logic [PW-1:0] find_old_prn(
        input int                           lane,
        input logic [N-1:0]                 ret,
        input logic [N-1:0][4:0]            arn,
        input logic [N-1:0][PW-1:0]         prn,
        input logic [ARCH_REGS-1:0][PW-1:0] map
    );
        logic [PW-1:0] old;
        old = map[arn[lane]];
        for (int j = 0; j < N; j++) begin
            if (j < lane && ret[j] && arn[j] == arn[lane])
                old = prn[j];
        end
        return old;
    endfunction

    function automatic int unsigned count_lanes(input logic [N-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < N; i++)
            c = c + int'(v[i]);
        return c;
    endfunction

    // Stage p0: in-order retire mask, frees, map merge and next state.
    always_comb begin
        retire_p0  = '0;
        free_p0    = '0;
        bp_p0      = '0;
        old_prn_p0 = '0;
        state_n    = state;
        blocked    = (state != RUN);
        for (int i = 0; i < N; i++) begin
            if (!blocked && ct_valid[i]) begin
                retire_p0[i] = 1'b1;
                bp_p0[i]     = ct_cond_branch[i] | ct_uncond_branch[i];
                if (ct_halt[i])
                    state_n = HALTED;
                if (ct_halt[i] || !ct_success[i])
                    blocked = 1'b1;
            end else begin
                blocked = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (retire_p0[i] && ct_dest_arn[i] != 5'd0) begin
                free_p0[i]    = 1'b1;
                old_prn_p0[i] = find_old_prn(i, retire_p0, ct_dest_arn, ct_dest_prn, arch_map);
            end
        end
    end

    always_comb begin
        map_n_p0 = arch_map;
        for (int i = 0; i < N; i++) begin
            if (free_p0[i])
                map_n_p0[ct_dest_arn[i]] = ct_dest_prn[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= RUN;
        else
            state <= state_n;
    end

    // Stage p1: registered retire results.
    always_ff @(posedge clock) begin
        if (reset) begin
            free_valid <= '0;
            free_prn   <= '0;
            bp_valid   <= '0;
            bp_pc      <= '0;
            bp_target  <= '0;
            bp_taken   <= '0;
            for (int k = 0; k < ARCH_REGS; k++)
                arch_map[k] <= PW'(k);
        end else begin
            free_valid <= free_p0;
            free_prn   <= old_prn_p0;
            bp_valid   <= bp_p0;
            arch_map   <= map_n_p0;
            for (int i = 0; i < N; i++) begin
                bp_pc[i]     <= bp_p0[i] ? ct_pc[i] : 32'd0;
                bp_target[i] <= bp_p0[i] ? ct_resolve_target[i] : 32'd0;
                bp_taken[i]  <= bp_p0[i] & ct_resolve_taken[i];
            end
        end
    end

`ifdef RETIRE_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            retire_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            retire_cnt     <= retire_cnt + 64'(count_lanes(retire_p0));
            mispredict_cnt <= mispredict_cnt + 32'(count_lanes(retire_p0 & ~ct_success));
        end
    end
`endif

    assign halted = (state == HALTED);

endmodule

// File: tb/tb_retire_stage.sv
// Bench for retire_stage (N=3, PRN width 6): directed vector table, random run against a lane-walk model, halt/reset sequences.
`timescale 1ns/1ps
module tb_retire_stage;

    logic clock = 1'b0;
    logic reset;
    logic [2:0]           ct_valid, ct_success, ct_halt, ct_cond_branch, ct_uncond_branch, ct_resolve_taken;
    logic [2:0][5:0]      ct_dest_prn;
    logic [2:0][4:0]      ct_dest_arn;
    logic [2:0][31:0]     ct_pc, ct_resolve_target;
    logic [2:0]           free_valid, bp_valid, bp_taken;
    logic [2:0][5:0]      free_prn;
    logic [31:0][5:0]     arch_map;
    logic [2:0][31:0]     bp_pc, bp_target;
    logic                 halted;
`ifdef RETIRE_STATS_EN
    logic [63:0]          retire_cnt;
    logic [31:0]          mispredict_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0][5:0] m_map;
    logic             m_halt;
    logic [63:0]      m_rc;
    logic [31:0]      m_mc;

    always #5 clock = ~clock;

    retire_stage #(.N(3), .ARCH_REGS(32)) dut (
        .clock(clock), .reset(reset),
`ifdef RETIRE_STATS_EN
        .retire_cnt(retire_cnt), .mispredict_cnt(mispredict_cnt),
`endif
        .ct_valid(ct_valid), .ct_dest_prn(ct_dest_prn), .ct_dest_arn(ct_dest_arn),
        .ct_success(ct_success), .ct_halt(ct_halt), .ct_cond_branch(ct_cond_branch),
        .ct_uncond_branch(ct_uncond_branch), .ct_pc(ct_pc), .ct_resolve_target(ct_resolve_target),
        .ct_resolve_taken(ct_resolve_taken), .free_valid(free_valid), .free_prn(free_prn),
        .arch_map(arch_map), .bp_valid(bp_valid), .bp_pc(bp_pc), .bp_target(bp_target),
        .bp_taken(bp_taken), .halted(halted)
    );

    typedef struct {
        logic [2:0]       valid, success, cond, uncond, taken;
        logic [2:0][4:0]  arn;
        logic [2:0][5:0]  prn;
        logic [2:0][31:0] target;
        logic [2:0]       exp_fv, exp_bv;
        logic [2:0][5:0]  exp_fp;
        logic [2:0][31:0] exp_bt;
        logic [4:0]       map_arn0, map_arn1;
        logic [5:0]       map_prn0, map_prn1;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        ct_valid = '0; ct_success = '1; ct_halt = '0; ct_cond_branch = '0;
        ct_uncond_branch = '0; ct_resolve_taken = '0; ct_dest_prn = '0;
        ct_dest_arn = '0; ct_pc = '0; ct_resolve_target = '0;
    endtask

    task automatic rand_inputs(input bit allow_halt);
        ct_valid = 3'($urandom);
        for (int i = 0; i < 3; i++) begin
            ct_dest_arn[i]       = 5'($urandom);
            ct_dest_prn[i]       = 6'($urandom);
            ct_success[i]        = ($urandom_range(0, 4) != 0);
            ct_halt[i]           = allow_halt && ($urandom_range(0, 7) == 0);
            ct_cond_branch[i]    = 1'($urandom);
            ct_uncond_branch[i]  = ($urandom_range(0, 3) == 0);
            ct_resolve_taken[i]  = 1'($urandom);
            ct_pc[i]             = 32'h1000 + $urandom_range(0, 4095) * 4;
            ct_resolve_target[i] = $urandom;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) m_map[k] = 6'(k);
        m_halt = 1'b0;
        m_rc   = '0;
        m_mc   = '0;
    endtask

    // Walk lanes oldest first; the running map naturally yields each lane's superseded PRN.
    task automatic model_step(output logic [2:0] fv, output logic [2:0][5:0] fp, output logic [2:0] bv);
        fv = '0; fp = '0; bv = '0;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_halt) return;
        for (int i = 0; i < 3; i++) begin
            if (!ct_valid[i]) break;
            m_rc = m_rc + 64'd1;
            if (!ct_success[i]) m_mc = m_mc + 32'd1;
            if (ct_dest_arn[i] != 5'd0) begin
                fv[i] = 1'b1;
                fp[i] = m_map[ct_dest_arn[i]];
                m_map[ct_dest_arn[i]] = ct_dest_prn[i];
            end
            if (ct_cond_branch[i] || ct_uncond_branch[i]) bv[i] = 1'b1;
            if (ct_halt[i]) begin
                m_halt = 1'b1;
                break;
            end
            if (!ct_success[i]) break;
        end
    endtask

    task automatic step_check(input string tag);
        logic [2:0] efv, ebv;
        logic [2:0][5:0] efp;
        model_step(efv, efp, ebv);
        @(posedge clock); #1;
        chk({tag, " free_valid"}, 192'(free_valid), 192'(efv));
        chk({tag, " bp_valid"}, 192'(bp_valid), 192'(ebv));
        for (int i = 0; i < 3; i++) begin
            if (efv[i]) chk({tag, " free_prn"}, 192'(free_prn[i]), 192'(efp[i]));
            if (ebv[i]) begin
                chk({tag, " bp_pc"}, 192'(bp_pc[i]), 192'(ct_pc[i]));
                chk({tag, " bp_target"}, 192'(bp_target[i]), 192'(ct_resolve_target[i]));
                chk({tag, " bp_taken"}, 192'(bp_taken[i]), 192'(ct_resolve_taken[i]));
            end
        end
        chk({tag, " arch_map"}, 192'(arch_map), 192'(m_map));
        chk({tag, " halted"}, 192'(halted), 192'(m_halt));
`ifdef RETIRE_STATS_EN
        chk({tag, " retire_cnt"}, 192'(retire_cnt), 192'(m_rc));
        chk({tag, " mispredict_cnt"}, 192'(mispredict_cnt), 192'(m_mc));
`endif
    endtask

    initial begin
        logic [2:0] dfv, dbv;
        logic [2:0][5:0] dfp;

        for (int k = 0; k < 6; k++) begin
            vecs[k] = '{valid: '0, success: '1, cond: '0, uncond: '0, taken: '0, arn: '0, prn: '0,
                        target: '0, exp_fv: '0, exp_bv: '0, exp_fp: '0, exp_bt: '0,
                        map_arn0: '0, map_arn1: '0, map_prn0: '0, map_prn1: '0};
        end
        // full group, distinct arns
        vecs[0].valid = 3'b111; vecs[0].arn = {5'd5, 5'd4, 5'd3}; vecs[0].prn = {6'd42, 6'd41, 6'd40};
        vecs[0].exp_fv = 3'b111; vecs[0].exp_fp = {6'd5, 6'd4, 6'd3};
        vecs[0].map_arn0 = 5'd3; vecs[0].map_prn0 = 6'd40; vecs[0].map_arn1 = 5'd5; vecs[0].map_prn1 = 6'd42;
        // same arn in two lanes
        vecs[1].valid = 3'b011; vecs[1].arn = {5'd0, 5'd7, 5'd7}; vecs[1].prn = {6'd0, 6'd51, 6'd50};
        vecs[1].exp_fv = 3'b011; vecs[1].exp_fp = {6'd0, 6'd50, 6'd7};
        vecs[1].map_arn0 = 5'd7; vecs[1].map_prn0 = 6'd51; vecs[1].map_arn1 = 5'd4; vecs[1].map_prn1 = 6'd41;
        // mispredicted cond branch in lane 1 drops lane 2
        vecs[2].valid = 3'b111; vecs[2].arn = {5'd10, 5'd9, 5'd8}; vecs[2].prn = {6'd22, 6'd21, 6'd20};
        vecs[2].success = 3'b101; vecs[2].cond = 3'b010; vecs[2].taken = 3'b010;
        vecs[2].target = {32'd0, 32'h100, 32'd0};
        vecs[2].exp_fv = 3'b011; vecs[2].exp_fp = {6'd0, 6'd9, 6'd8}; vecs[2].exp_bv = 3'b010;
        vecs[2].exp_bt = {32'd0, 32'h100, 32'd0};
        vecs[2].map_arn0 = 5'd9; vecs[2].map_prn0 = 6'd21; vecs[2].map_arn1 = 5'd10; vecs[2].map_prn1 = 6'd10;
        // arn 0 lane is not freed, later lane sees earlier map update
        vecs[3].valid = 3'b011; vecs[3].arn = {5'd0, 5'd3, 5'd0}; vecs[3].prn = {6'd0, 6'd30, 6'd9};
        vecs[3].exp_fv = 3'b010; vecs[3].exp_fp = {6'd0, 6'd40, 6'd0};
        vecs[3].map_arn0 = 5'd0; vecs[3].map_prn0 = 6'd0; vecs[3].map_arn1 = 5'd3; vecs[3].map_prn1 = 6'd30;
        // valid gap at lane 0 stops everything
        vecs[4].valid = 3'b010; vecs[4].arn = {5'd0, 5'd11, 5'd0}; vecs[4].prn = {6'd0, 6'd33, 6'd0};
        vecs[4].map_arn0 = 5'd11; vecs[4].map_prn0 = 6'd11; vecs[4].map_arn1 = 5'd3; vecs[4].map_prn1 = 6'd30;
        // three lanes same arn, uncond branch in youngest
        vecs[5].valid = 3'b111; vecs[5].arn = {5'd12, 5'd12, 5'd12}; vecs[5].prn = {6'd3, 6'd2, 6'd1};
        vecs[5].uncond = 3'b100; vecs[5].taken = 3'b100; vecs[5].target = {32'h200, 32'd0, 32'd0};
        vecs[5].exp_fv = 3'b111; vecs[5].exp_fp = {6'd2, 6'd1, 6'd12}; vecs[5].exp_bv = 3'b100;
        vecs[5].exp_bt = {32'h200, 32'd0, 32'd0};
        vecs[5].map_arn0 = 5'd12; vecs[5].map_prn0 = 6'd3; vecs[5].map_arn1 = 5'd11; vecs[5].map_prn1 = 6'd11;

        reset = 1'b1;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("reset free_valid", 192'(free_valid), 192'(3'b000));
        chk("reset bp_valid", 192'(bp_valid), 192'(3'b000));
        chk("reset halted", 192'(halted), 192'(1'b0));
        step_check("idle");
        chk("idle arch_map[5]", 192'(arch_map[5]), 192'(6'd5));
        chk("idle free_valid", 192'(free_valid), 192'(3'b000));

        for (int k = 0; k < 6; k++) begin
            drive_idle();
            ct_valid = vecs[k].valid; ct_success = vecs[k].success; ct_cond_branch = vecs[k].cond;
            ct_uncond_branch = vecs[k].uncond; ct_resolve_taken = vecs[k].taken;
            ct_dest_arn = vecs[k].arn; ct_dest_prn = vecs[k].prn; ct_resolve_target = vecs[k].target;
            model_step(dfv, dfp, dbv);
            @(posedge clock); #1;
            chk($sformatf("vec%0d free_valid", k), 192'(free_valid), 192'(vecs[k].exp_fv));
            chk($sformatf("vec%0d bp_valid", k), 192'(bp_valid), 192'(vecs[k].exp_bv));
            for (int i = 0; i < 3; i++) begin
                if (vecs[k].exp_fv[i])
                    chk($sformatf("vec%0d free_prn%0d", k, i), 192'(free_prn[i]), 192'(vecs[k].exp_fp[i]));
                if (vecs[k].exp_bv[i]) begin
                    chk($sformatf("vec%0d bp_target%0d", k, i), 192'(bp_target[i]), 192'(vecs[k].exp_bt[i]));
                    chk($sformatf("vec%0d bp_taken%0d", k, i), 192'(bp_taken[i]), 192'(1'b1));
                end
            end
            chk($sformatf("vec%0d map_a", k), 192'(arch_map[vecs[k].map_arn0]), 192'(vecs[k].map_prn0));
            chk($sformatf("vec%0d map_b", k), 192'(arch_map[vecs[k].map_arn1]), 192'(vecs[k].map_prn1));
        end

        for (int t = 0; t < 300; t++) begin
            rand_inputs(1'b0);
            step_check("rand");
        end

        // reset mid-group discards inputs
        rand_inputs(1'b0);
        ct_valid = 3'b111;
        reset = 1'b1;
        step_check("rst_mid");
        reset = 1'b0;
        chk("rst_mid arch_map[7]", 192'(arch_map[7]), 192'(6'd7));

        // halt in lane 0 drops lane 1 and freezes the stage
        drive_idle();
        ct_valid = 3'b011; ct_halt = 3'b001;
        ct_dest_arn = {5'd0, 5'd14, 5'd13}; ct_dest_prn = {6'd0, 6'd45, 6'd44};
        step_check("halt");
        chk("halt halted", 192'(halted), 192'(1'b1));
        chk("halt free_valid", 192'(free_valid), 192'(3'b001));
        chk("halt free_prn0", 192'(free_prn[0]), 192'(6'd13));
        chk("halt map[14]", 192'(arch_map[14]), 192'(6'd14));
`ifdef RETIRE_STATS_EN
        chk("halt retire_cnt", 192'(retire_cnt), 192'(64'd1));
`endif
        for (int t = 0; t < 6; t++) begin
            rand_inputs(1'b1);
            ct_valid = 3'b111;
            step_check("halted");
            chk("halted free_valid", 192'(free_valid), 192'(3'b000));
            chk("halted bp_valid", 192'(bp_valid), 192'(3'b000));
            chk("halted stays", 192'(halted), 192'(1'b1));
        end

        // reset while halted
        rand_inputs(1'b1);
        ct_valid = 3'b111;
        reset = 1'b1;
        step_check("rst_halt");
        reset = 1'b0;
        chk("rst_halt halted", 192'(halted), 192'(1'b0));
        for (int t = 0; t < 20; t++) begin
            rand_inputs(1'b1);
            step_check("post");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
